// File: rtl/mips_ex_issue.sv
// ID/EX issue stage: one-entry valid/ready register that resolves ALU operands with WB bypass and EX/MEM forwarding.
// Optional EX/MEM forwarding is enabled by defining EXS_MEM_FWD_EN; otherwise the MEM_* ports are ignored.
module mips_ex_issue #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [RW-1:0] IN_RS,
  input  logic [RW-1:0] IN_RT,
  input  logic [DW-1:0] IN_QA,
  input  logic [DW-1:0] IN_QB,
  input  logic [15:0]   IN_IMM,
  input  logic [4:0]    IN_SHAMT,
  input  logic [3:0]    IN_ALUC,
  input  logic          IN_SHIFT,
  input  logic          IN_ALUIMM,
  input  logic          IN_SEXT,
  input  logic          IN_WREG,
  input  logic [RW-1:0] IN_RN,
  input  logic          FLUSH,
  input  logic          WB_WE,
  input  logic [RW-1:0] WB_RN,
  input  logic [DW-1:0] WB_D,
  input  logic          MEM_WE,
  input  logic [RW-1:0] MEM_RN,
  input  logic [DW-1:0] MEM_D,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [3:0]    ALUC,
  output logic [DW-1:0] STORE_D,
  output logic          OUT_WREG,
  output logic [RW-1:0] OUT_RN
);

  localparam int unsigned IMMW = 16;
  localparam int unsigned SHW  = 5;
  localparam int unsigned ACW  = 4;

  logic            valid_q, valid_d;
  logic [RW-1:0]   rs_q, rs_d, rt_q, rt_d, rn_q, rn_d;
  logic [DW-1:0]   qa_q, qa_d, qb_q, qb_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic [SHW-1:0]  shamt_q, shamt_d;
  logic [ACW-1:0]  aluc_q, aluc_d;
  logic            shift_q, shift_d;
  logic            aluimm_q, aluimm_d;
  logic            sext_q, sext_d;
  logic            wreg_q, wreg_d;

  logic            capture, leave, stall;
  logic [DW-1:0]   fwd_rs, fwd_rt, ext_imm;

  always_comb begin
    IN_READY = !valid_q || OUT_READY;
    capture  = IN_VALID && IN_READY && !FLUSH;
    leave    = valid_q && OUT_READY;
    stall    = valid_q && !OUT_READY;
  end

  // Next-state: handshake occupancy plus capture-time bypass and hold-time WB refresh.
  always_comb begin
    valid_d  = valid_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rn_d     = rn_q;
    qa_d     = qa_q;
    qb_d     = qb_q;
    imm_d    = imm_q;
    shamt_d  = shamt_q;
    aluc_d   = aluc_q;
    shift_d  = shift_q;
    aluimm_d = aluimm_q;
    sext_d   = sext_q;
    wreg_d   = wreg_q;

    if (FLUSH)        valid_d = 1'b0;
    else if (capture) valid_d = 1'b1;
    else if (leave)   valid_d = 1'b0;

    if (capture) begin
      rs_d     = IN_RS;
      rt_d     = IN_RT;
      rn_d     = IN_RN;
      imm_d    = IN_IMM;
      shamt_d  = IN_SHAMT;
      aluc_d   = IN_ALUC;
      shift_d  = IN_SHIFT;
      aluimm_d = IN_ALUIMM;
      sext_d   = IN_SEXT;
      wreg_d   = IN_WREG;
      qa_d     = (WB_WE && (WB_RN == IN_RS) && (IN_RS != '0)) ? WB_D : IN_QA;
      qb_d     = (WB_WE && (WB_RN == IN_RT) && (IN_RT != '0)) ? WB_D : IN_QB;
    end else if (stall) begin
      if (WB_WE && (WB_RN == rs_q) && (rs_q != '0)) qa_d = WB_D;
      if (WB_WE && (WB_RN == rt_q) && (rt_q != '0)) qb_d = WB_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rn_q     <= '0;
      qa_q     <= '0;
      qb_q     <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      aluc_q   <= '0;
      shift_q  <= 1'b0;
      aluimm_q <= 1'b0;
      sext_q   <= 1'b0;
      wreg_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rn_q     <= rn_d;
      qa_q     <= qa_d;
      qb_q     <= qb_d;
      imm_q    <= imm_d;
      shamt_q  <= shamt_d;
      aluc_q   <= aluc_d;
      shift_q  <= shift_d;
      aluimm_q <= aluimm_d;
      sext_q   <= sext_d;
      wreg_q   <= wreg_d;
    end
  end

`ifdef EXS_MEM_FWD_EN
  // The in-flight EX/MEM result is newer than anything held here.
  always_comb begin
    fwd_rs = (MEM_WE && (MEM_RN == rs_q) && (rs_q != '0)) ? MEM_D : qa_q;
    fwd_rt = (MEM_WE && (MEM_RN == rt_q) && (rt_q != '0)) ? MEM_D : qb_q;
  end
`else
  logic unused_mem;
  always_comb begin
    fwd_rs     = qa_q;
    fwd_rt     = qb_q;
    unused_mem = ^{MEM_WE, MEM_RN, MEM_D};
  end
`endif

  always_comb begin
    ext_imm   = sext_q ? {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q} : {{(DW-IMMW){1'b0}}, imm_q};
    A         = shift_q ? {{(DW-SHW){1'b0}}, shamt_q} : fwd_rs;
    B         = aluimm_q ? ext_imm : fwd_rt;
    STORE_D   = fwd_rt;
    ALUC      = aluc_q;
    OUT_VALID = valid_q;
    OUT_WREG  = wreg_q;
    OUT_RN    = rn_q;
  end

endmodule

// File: tb/tb_mips_ex_issue.sv
// Bench for mips_ex_issue: a register-file-level model predicts the operands the held instruction must see.
module tb_mips_ex_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rn, in_shamt;
  logic [31:0] in_qa, in_qb;
  logic [15:0] in_imm;
  logic [3:0]  in_aluc;
  logic        in_shift, in_aluimm, in_sext, in_wreg, flush;
  logic        wb_we, mem_we, out_valid, out_ready, out_wreg;
  logic [4:0]  wb_rn, mem_rn, out_rn;
  logic [31:0] wb_d, mem_d, a, b, store_d;
  logic [3:0]  aluc;

  mips_ex_issue #(.DW(32), .RW(5)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_RS(in_rs), .IN_RT(in_rt), .IN_QA(in_qa), .IN_QB(in_qb),
    .IN_IMM(in_imm), .IN_SHAMT(in_shamt), .IN_ALUC(in_aluc),
    .IN_SHIFT(in_shift), .IN_ALUIMM(in_aluimm), .IN_SEXT(in_sext),
    .IN_WREG(in_wreg), .IN_RN(in_rn), .FLUSH(flush),
    .WB_WE(wb_we), .WB_RN(wb_rn), .WB_D(wb_d),
    .MEM_WE(mem_we), .MEM_RN(mem_rn), .MEM_D(mem_d),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .A(a), .B(b), .ALUC(aluc), .STORE_D(store_d),
    .OUT_WREG(out_wreg), .OUT_RN(out_rn)
  );

  always #5 clk = ~clk;

  // Architectural register file seen by decode; r0 is never written.
  logic [31:0] rf [32];

  // The instruction the stage should currently be holding.
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_rn, m_shamt;
  logic [15:0] m_imm;
  logic [3:0]  m_aluc;
  logic        m_shift, m_aluimm, m_sext, m_wreg;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Newest value of register r as the ALU must see it.
  function automatic logic [31:0] newest(input logic [4:0] r);
`ifdef EXS_MEM_FWD_EN
    if (mem_we && mem_rn == r && r != 5'd0) return mem_d;
`endif
    return rf[r];
  endfunction

  task automatic model_edge();
    logic accept;
    accept = !m_valid || out_ready;
    if (rst || flush) m_valid = 1'b0;
    else if (in_valid && accept) begin
      m_valid = 1'b1;
      m_rs = in_rs; m_rt = in_rt; m_rn = in_rn; m_shamt = in_shamt;
      m_imm = in_imm; m_aluc = in_aluc; m_shift = in_shift;
      m_aluimm = in_aluimm; m_sext = in_sext; m_wreg = in_wreg;
    end else if (m_valid && out_ready) m_valid = 1'b0;
    if (wb_we && wb_rn != 5'd0) rf[wb_rn] = wb_d;
  endtask

  task automatic compare();
    logic [31:0] ext;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      ext = m_sext ? 32'($signed(m_imm)) : 32'(m_imm);
      chk("A", a, m_shift ? 32'(m_shamt) : newest(m_rs));
      chk("B", b, m_aluimm ? ext : newest(m_rt));
      chk("STORE_D", store_d, newest(m_rt));
      chk("ALUC", 32'(aluc), 32'(m_aluc));
      chk("OUT_WREG", 32'(out_wreg), 32'(m_wreg));
      chk("OUT_RN", 32'(out_rn), 32'(m_rn));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; mem_we = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic [4:0] shamt, input logic [3:0] op,
                       input logic shift, input logic aluimm, input logic sext);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_qa = rf[rs]; in_qb = rf[rt];
    in_imm = imm; in_shamt = shamt; in_aluc = op; in_shift = shift;
    in_aluimm = aluimm; in_sext = sext; in_wreg = 1'b1; in_rn = rt;
  endtask

  task automatic wb(input logic [4:0] rn, input logic [31:0] d);
    wb_we = 1'b1; wb_rn = rn; wb_d = d;
  endtask

  initial begin
    foreach (rf[i]) rf[i] = 32'd0;
    m_valid = 1'b0;
    idle();
    rst = 1'b1; out_ready = 1'b1;
    in_rs = '0; in_rt = '0; in_qa = '0; in_qb = '0; in_imm = '0; in_shamt = '0;
    in_aluc = '0; in_shift = 1'b0; in_aluimm = 1'b0; in_sext = 1'b0; in_wreg = 1'b0;
    in_rn = '0; wb_rn = '0; wb_d = '0; mem_rn = '0; mem_d = '0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_A", a, 32'd0);
    chk("rst_B", b, 32'd0);
    chk("rst_STORE_D", store_d, 32'd0);
    chk("rst_ALUC", 32'(aluc), 32'd0);
    chk("rst_OUT_RN", 32'(out_rn), 32'd0);
    chk("rst_OUT_WREG", 32'(out_wreg), 32'd0);

    // Populate r1=5, r2=7, then add r1,r2.
    wb(5'd1, 32'd5); cycle();
    wb(5'd2, 32'd7); cycle();
    wb_we = 1'b0;
    issue(5'd1, 5'd2, 16'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_A", a, 32'd5);
    chk("add_B", b, 32'd7);
    chk("add_ALUC", 32'(aluc), 32'd0);

    issue(5'd1, 5'd2, 16'hFFFF, 5'd0, 4'b0010, 1'b0, 1'b1, 1'b1);
    wb(5'd3, 32'd1);
    cycle();
    chk("addi_sext_B", b, 32'hFFFFFFFF);
    wb_we = 1'b0;
    issue(5'd1, 5'd2, 16'hFFFF, 5'd0, 4'b0010, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("addi_zext_B", b, 32'h0000FFFF);

    issue(5'd0, 5'd3, 16'h0, 5'd3, 4'b0011, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("sll_A", a, 32'd3);
    chk("sll_B", b, 32'd1);

    // Capture-time bypass, then hold-time refresh during a stall.
    issue(5'd4, 5'd0, 16'h0, 5'd0, 4'b0001, 1'b0, 1'b0, 1'b0);
    wb(5'd4, 32'hAA);
    cycle();
    chk("bypass_A", a, 32'hAA);
    in_valid = 1'b0; out_ready = 1'b0;
    wb(5'd4, 32'hBB);
    cycle();
    chk("hold_A1", a, 32'hBB);
    wb_we = 1'b0;
    cycle(); cycle();
    chk("hold_A3", a, 32'hBB);
    chk("hold_valid", 32'(out_valid), 32'd1);

    mem_we = 1'b1; mem_rn = 5'd4; mem_d = 32'h11;
    cycle();
`ifdef EXS_MEM_FWD_EN
    chk("memfwd_A", a, 32'h11);
`else
    chk("memfwd_A", a, 32'hBB);
`endif
    out_ready = 1'b1; mem_rn = 5'd0;
    issue(5'd0, 5'd0, 16'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("r0_nofwd_A", a, 32'd0);
    idle();

    // Flush of a stalled entry drops the simultaneous offer too.
    issue(5'd5, 5'd1, 16'h0, 5'd0, 4'b0100, 1'b0, 1'b0, 1'b0);
    cycle();
    out_ready = 1'b0;
    issue(5'd6, 5'd2, 16'h0, 5'd0, 4'b0101, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    cycle();
    chk("flush_valid", 32'(out_valid), 32'd0);
    idle();
    cycle();
    chk("flush_dropped", 32'(out_valid), 32'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(5'(i + 1), 5'(i + 2), 16'(i), 5'(i), 4'(i), 1'b0, 1'b0, 1'b0);
      cycle();
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end

    // Reset while stalled loses the entry.
    idle(); out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_stall_valid", 32'(out_valid), 32'd0);

    // Randomised traffic over a small register window to provoke hazards.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0)
        issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom),
              5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else in_valid = 1'b0;
      in_wreg = 1'($urandom);
      in_rn   = 5'($urandom);
      wb_we   = 1'($urandom);
      wb_rn   = 5'($urandom_range(0, 7));
      wb_d    = $urandom;
      mem_we  = 1'($urandom);
      mem_rn  = 5'($urandom_range(0, 7));
      mem_d   = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_ex_issue.md
Name: mips_ex_issue

Overview:
- Registered ID/EX issue stage that sits directly upstream of the 32-bit MIPS ALU. It holds one decoded instruction at a time.
- It resolves register operands using writeback bypass and EX/MEM forwarding, then forms the ALU inputs: A (rs value or shamt), B (rt value or extended immediate), and ALUC.
- A valid/ready handshake is used on both sides, with a synchronous flush for branch redirect.

Parameters:
- DW, 32, datapath width; the ALU is built for 32.
- RW, 5, register-number width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- IN_VALID  in  1  decode stage offers an instruction.
- IN_READY  out  1  stage can accept; equals !OUT_VALID || OUT_READY.
- IN_RS, IN_RT  in  RW  source register numbers.
- IN_QA, IN_QB  in  DW  register-file read data for rs and rt.
- IN_IMM  in  16  immediate field.
- IN_SHAMT  in  5  shift amount field.
- IN_ALUC  in  4  ALU opcode, passed through unchanged.
- IN_SHIFT  in  1  A takes the zero-extended shamt instead of rs.
- IN_ALUIMM  in  1  B takes the extended immediate instead of rt.
- IN_SEXT  in  1  1 = sign-extend the immediate, 0 = zero-extend.
- IN_WREG  in  1  instruction writes a register.
- IN_RN  in  RW  destination register number.
- FLUSH  in  1  discard the held and incoming instruction.
- WB_WE, WB_RN, WB_D  in  1/RW/DW  writeback-stage write port.
- MEM_WE, MEM_RN, MEM_D  in  1/RW/DW  EX/MEM result, used for forwarding.
- OUT_VALID  out  1  A, B, ALUC and the sideband outputs are valid.
- OUT_READY  in  1  downstream accepts the held instruction.
- A, B  out  DW  ALU operands.
- ALUC  out  4  ALU opcode.
- STORE_D  out  DW  forwarded rt value, used as sw data.
- OUT_WREG, OUT_RN  out  1/RW  registered IN_WREG and IN_RN.

Behaviour:
- Reset: all registers clear to 0, including OUT_VALID, stored operands, control bits, ALUC, OUT_WREG and OUT_RN.
  - A, B, ALUC, STORE_D, OUT_WREG and OUT_RN therefore read 0 until the first capture.
- Stage register: a single entry.
  - Capture occurs when IN_VALID && IN_READY && !FLUSH. On capture, OUT_VALID goes to 1 the next cycle (latency 1).
  - Release occurs when OUT_VALID && OUT_READY. If there is no new capture in the same cycle, OUT_VALID goes to 0.
  - Simultaneous release and capture replace the entry with no bubble, giving full throughput.
- FLUSH: highest priority below RST.
  - Next cycle, OUT_VALID = 0 and any same-cycle input is dropped. IN_READY is unaffected.
  - Stored data does not need clearing.
- Capture-time bypass: if WB_WE && WB_RN == IN_RS && IN_RS != 0, the stored rs value is WB_D; otherwise it is IN_QA. The same rule applies to rt with IN_QB.
- Hold-time update: while OUT_VALID && !OUT_READY, a WB write matching a stored nonzero rs/rt overwrites that stored value.
  - This covers producers that move from MEM to WB during a stall.
- EX/MEM forwarding (combinational on the output): fwd_rs = MEM_D if MEM_WE && MEM_RN == rs_q && rs_q != 0; otherwise the stored rs value. The same rule gives fwd_rt.
  - MEM takes priority over the stored value.
- Register 0 is never bypassed or forwarded.
- Operand formation:
  - A = shift_q ? {27'b0, shamt_q} : fwd_rs.
  - B = aluimm_q ? ext(imm_q) : fwd_rt, where ext sign- or zero-extends to DW per sext_q.
  - STORE_D = fwd_rt.
  - ALUC = aluc_q.
- While OUT_VALID = 0, the outputs hold their last values. Consumers must ignore them.
- Throughout a stall, A, B, ALUC and STORE_D follow the stored state plus forwarding; there are no other changes.
- RST mid-stall: the entry is lost, and OUT_VALID = 0 next cycle.

Optional Feature:
- Macro EXS_MEM_FWD_EN.
  - Defined: EX/MEM forwarding is active as described above.
  - Undefined: the MEM_* ports remain present but are ignored, and fwd_rs/fwd_rt are the stored values. Writeback bypass and hold-time update are unchanged.
  - In the undefined case, the hazard unit must stall for ALU-result dependencies.

Test Plan:
- Reset, then add with rs=1 (QA=5), rt=2 (QB=7), ALUC=0000, OUT_READY=1 -> one cycle later OUT_VALID=1, A=5, B=7, ALUC=0000.
- addi with IMM=16'hFFFF, SEXT=1 -> B=32'hFFFFFFFF; same with SEXT=0 -> B=32'h0000FFFF.
- sll with SHIFT=1, SHAMT=3, rt value 1 -> A=3, B=1.
- Capture rs=4 with QA=0 while WB writes r4=32'hAA -> A=32'hAA. Next, hold OUT_READY=0 for 3 cycles while WB writes r4=32'hBB -> A=32'hBB after the write.
- With macro defined: MEM_WE=1, MEM_RN=4, MEM_D=32'h11 while rs_q=4 -> A=32'h11. With MEM_RN=0 and rs=0 -> no forward, A=stored value.
- Valid entry held with OUT_READY=0, then assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0 and the new instruction is not captured. Back-to-back captures with OUT_READY=1 give OUT_VALID=1 on every cycle with no bubble.
